// File: rtl/demux_valid_n_if.sv
// Stream bundle for demux_valid_n: upstream word/valid/ready plus per-lane
// valid/ready/data, with the monitor tap (data_tran, drop).
interface demux_valid_n_if #(
   parameter int WIDTH   = 4,
   parameter int NUM_OUT = 2
);
   localparam int SEL_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   logic                     mode;
   logic [SEL_W-1:0]         sel_in;
   logic                     valid_in;
   logic [WIDTH-1:0]         data_in;
   logic                     ready_in;
   logic [NUM_OUT-1:0]       ready_out;
   logic [NUM_OUT-1:0]       valid_out;
   logic [NUM_OUT*WIDTH-1:0] data_out;
   logic [WIDTH-1:0]         data_tran;
   logic                     drop;

   // Source and consumers side.
   modport master (
      output mode, sel_in, valid_in, data_in, ready_out,
      input  ready_in, valid_out, data_out, data_tran, drop
   );

   // Demux side.
   modport slave (
      input  mode, sel_in, valid_in, data_in, ready_out,
      output ready_in, valid_out, data_out, data_tran, drop
   );
endinterface

// File: rtl/demux_valid_n.sv
// Routes a valid-qualified word stream to NUM_OUT one-entry lanes, either
// round-robin (mode=0) or by sel_in (mode=1); out-of-range selects are dropped.
module demux_valid_n #(
   parameter int WIDTH   = 4,
   parameter int NUM_OUT = 2
) (
   input  logic           clk,
   input  logic           reset_L,
   demux_valid_n_if.slave bus
);
   localparam int SEL_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   logic [SEL_W-1:0]   ptr_reg;
   logic [SEL_W-1:0]   ptr_next;
   logic [SEL_W-1:0]   tgt;
   logic               tgt_bad;
   logic               ready;
   logic               accept;
   logic               load_ok;
   logic [NUM_OUT-1:0] valid_vec;
   logic [NUM_OUT-1:0] load_vec;
   logic [WIDTH-1:0]   data_arr [NUM_OUT];
   logic [WIDTH-1:0]   tran_reg;
   logic               drop_reg;

   // Ready looks only at the targeted lane; a bad select always accepts so it can be discarded.
   always_comb begin
      tgt     = bus.mode ? bus.sel_in : ptr_reg;
      tgt_bad = bus.mode && ({1'b0, bus.sel_in} >= (SEL_W+1)'(NUM_OUT));
      ready   = tgt_bad ? 1'b1 : (!valid_vec[tgt] || bus.ready_out[tgt]);
      accept  = bus.valid_in && ready;
      load_ok = accept && !tgt_bad;
   end

   always_comb begin
      ptr_next = ptr_reg;
      if (load_ok && !bus.mode) begin
         ptr_next = (ptr_reg == SEL_W'(NUM_OUT - 1)) ? '0 : ptr_reg + SEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         ptr_reg  <= '0;
         tran_reg <= '0;
         drop_reg <= 1'b0;
      end else begin
         ptr_reg  <= ptr_next;
         drop_reg <= accept && tgt_bad;
         if (accept) begin
            tran_reg <= bus.data_in;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;

      assign load_vec[gi] = load_ok && (tgt == SEL_W'(gi));

      // A load wins over a drain so a lane can refill every cycle.
      always_ff @(posedge clk or negedge reset_L) begin
         if (!reset_L) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
         end else if (load_vec[gi]) begin
            valid_reg <= 1'b1;
            data_reg  <= bus.data_in;
         end else if (valid_reg && bus.ready_out[gi]) begin
            valid_reg <= 1'b0;
         end
      end

      assign valid_vec[gi] = valid_reg;
      assign data_arr[gi]  = data_reg;
   end

   always_comb begin
      bus.data_out = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         bus.data_out[i*WIDTH +: WIDTH] = data_arr[i];
      end
   end

   assign bus.ready_in  = ready;
   assign bus.valid_out = valid_vec;
   assign bus.data_tran = tran_reg;
   assign bus.drop      = drop_reg;
endmodule

// File: tb/tb_demux_valid_n.sv
// Bench for demux_valid_n (WIDTH=4, NUM_OUT=3): per-lane scoreboard queues
// filled on accepted words and drained on lane handoffs, plus directed scenarios.
module tb_demux_valid_n;
   localparam int WIDTH   = 4;
   localparam int NUM_OUT = 3;

   logic clk     = 1'b0;
   logic reset_L = 1'b0;
   always #5 clk = ~clk;

   demux_valid_n_if #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT)) bus ();

   demux_valid_n #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] sb_q [NUM_OUT][$];
   int               m_ptr  = 0;
   logic [WIDTH-1:0] m_tran = '0;
   logic             m_drop = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: compare against the model mid-cycle, then apply the events of the next edge.
   always @(negedge clk or negedge reset_L) begin
      logic sel_bad;
      logic exp_rdy;
      int   tgt;
      if (!reset_L) begin
         for (int i = 0; i < NUM_OUT; i++) sb_q[i].delete();
         m_ptr  = 0;
         m_tran = '0;
         m_drop = 1'b0;
      end else begin
         for (int i = 0; i < NUM_OUT; i++) begin
            check_val($sformatf("valid%0d", i), 32'(bus.valid_out[i]), 32'(sb_q[i].size() != 0));
            if (sb_q[i].size() != 0)
               check_val($sformatf("data%0d", i), 32'(bus.data_out[i*WIDTH +: WIDTH]), 32'(sb_q[i][0]));
         end
         check_val("data_tran", 32'(bus.data_tran), 32'(m_tran));
         check_val("drop", 32'(bus.drop), 32'(m_drop));

         sel_bad = bus.mode && (int'(bus.sel_in) >= NUM_OUT);
         tgt     = bus.mode ? int'(bus.sel_in) : m_ptr;
         if (sel_bad) exp_rdy = 1'b1;
         else         exp_rdy = (sb_q[tgt].size() == 0) || bus.ready_out[tgt];
         check_val("ready_in", 32'(bus.ready_in), 32'(exp_rdy));

         for (int i = 0; i < NUM_OUT; i++) begin
            if (sb_q[i].size() != 0 && bus.ready_out[i]) begin
               $display("out  ch%0d data=%h", i, sb_q[i][0]);
               void'(sb_q[i].pop_front());
            end
         end

         if (bus.valid_in && exp_rdy) begin
            m_tran = bus.data_in;
            m_drop = sel_bad;
            if (!sel_bad) begin
               sb_q[tgt].push_back(bus.data_in);
               if (!bus.mode) m_ptr = (m_ptr + 1) % NUM_OUT;
            end
            $display("in   data=%h mode=%0b tgt=%0d drop=%0b", bus.data_in, bus.mode, tgt, sel_bad);
         end else begin
            m_drop = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [WIDTH-1:0] words [4];
      logic [2:0]       rr_pat [4];
      int               rr_ch [4];

      bus.mode      = 1'b0;
      bus.sel_in    = '0;
      bus.valid_in  = 1'b0;
      bus.data_in   = '0;
      bus.ready_out = '0;

      // Reset state
      #12;
      check_val("rst_valid", 32'(bus.valid_out), 32'h0);
      check_val("rst_data", 32'(bus.data_out), 32'h0);
      check_val("rst_tran", 32'(bus.data_tran), 32'h0);
      check_val("rst_drop", 32'(bus.drop), 32'h0);
      tick();
      reset_L = 1'b1;

      // Round-robin stream, full downstream throughput
      words  = '{4'hA, 4'hB, 4'hC, 4'hD};
      rr_pat = '{3'b001, 3'b010, 3'b100, 3'b001};
      rr_ch  = '{0, 1, 2, 0};
      bus.ready_out = 3'b111;
      for (int k = 0; k < 4; k++) begin
         bus.valid_in = 1'b1;
         bus.data_in  = words[k];
         tick();
         check_val("rr_valid", 32'(bus.valid_out), 32'(rr_pat[k]));
         check_val("rr_data", 32'(bus.data_out[rr_ch[k]*WIDTH +: WIDTH]), 32'(words[k]));
         check_val("rr_tran", 32'(bus.data_tran), 32'(words[k]));
      end
      bus.valid_in = 1'b0;
      tick();
      check_val("rr_idle", 32'(bus.valid_out), 32'h0);

      // Back-pressure: pointer is at 1; fill all lanes, then stall on ch1
      bus.ready_out = 3'b000;
      words = '{4'h1, 4'h2, 4'h3, 4'h4};
      for (int k = 0; k < 3; k++) begin
         bus.valid_in = 1'b1;
         bus.data_in  = words[k];
         tick();
      end
      bus.data_in = 4'h4;
      #1;
      check_val("bp_stall", 32'(bus.ready_in), 32'h0);
      tick();
      bus.data_in = 4'hE;
      tick();
      check_val("bp_held", 32'(bus.data_out[1*WIDTH +: WIDTH]), 32'h1);
      bus.data_in   = 4'h4;
      bus.ready_out = 3'b010;
      #1;
      check_val("bp_release", 32'(bus.ready_in), 32'h1);
      tick();
      check_val("bp_valid", 32'(bus.valid_out), 32'h7);
      check_val("bp_ch1", 32'(bus.data_out[1*WIDTH +: WIDTH]), 32'h4);
      check_val("bp_ch2", 32'(bus.data_out[2*WIDTH +: WIDTH]), 32'h2);
      bus.valid_in = 1'b0;
      tick();
      check_val("bp_drain1", 32'(bus.valid_out), 32'h5);
      bus.ready_out = 3'b111;
      tick();

      // Select mode: ch2 twice back-to-back, then ch0 (pointer now 2)
      bus.mode = 1'b1;
      words  = '{4'h5, 4'h6, 4'h7, 4'h0};
      rr_pat = '{3'b100, 3'b100, 3'b001, 3'b000};
      rr_ch  = '{2, 2, 0, 0};
      for (int k = 0; k < 3; k++) begin
         bus.valid_in = 1'b1;
         bus.sel_in   = 2'(rr_ch[k]);
         bus.data_in  = words[k];
         tick();
         check_val("sel_valid", 32'(bus.valid_out), 32'(rr_pat[k]));
         check_val("sel_data", 32'(bus.data_out[rr_ch[k]*WIDTH +: WIDTH]), 32'(words[k]));
      end
      bus.valid_in = 1'b0;
      tick();

      // Invalid select is consumed and dropped
      bus.valid_in = 1'b1;
      bus.sel_in   = 2'd3;
      bus.data_in  = 4'hF;
      #1;
      check_val("drop_ready", 32'(bus.ready_in), 32'h1);
      tick();
      check_val("drop_pulse", 32'(bus.drop), 32'h1);
      check_val("drop_valid", 32'(bus.valid_out), 32'h0);
      check_val("drop_tran", 32'(bus.data_tran), 32'hF);
      bus.valid_in = 1'b0;
      tick();
      check_val("drop_clear", 32'(bus.drop), 32'h0);

      // Pointer held through select mode: next round-robin word goes to ch2
      bus.mode     = 1'b0;
      bus.valid_in = 1'b1;
      bus.data_in  = 4'h8;
      tick();
      check_val("ptr_hold", 32'(bus.valid_out), 32'h4);
      bus.valid_in = 1'b0;
      tick();

      // Mid-operation asynchronous reset with ch0/ch1 full
      bus.ready_out = 3'b000;
      words = '{4'h9, 4'hA, 4'h0, 4'h0};
      for (int k = 0; k < 2; k++) begin
         bus.valid_in = 1'b1;
         bus.data_in  = words[k];
         tick();
      end
      bus.valid_in = 1'b0;
      check_val("mr_full", 32'(bus.valid_out), 32'h3);
      #2;
      reset_L = 1'b0;
      #1;
      check_val("mr_valid", 32'(bus.valid_out), 32'h0);
      check_val("mr_data", 32'(bus.data_out), 32'h0);
      check_val("mr_tran", 32'(bus.data_tran), 32'h0);
      reset_L = 1'b1;
      bus.ready_out = 3'b111;
      tick();
      bus.valid_in = 1'b1;
      bus.data_in  = 4'hB;
      tick();
      check_val("mr_first", 32'(bus.valid_out), 32'h1);
      check_val("mr_first_data", 32'(bus.data_out[0 +: WIDTH]), 32'hB);

      // Mode switch: pointer is 1, a select-mode word must not move it
      bus.mode    = 1'b1;
      bus.sel_in  = 2'd0;
      bus.data_in = 4'h2;
      tick();
      check_val("ms_sel", 32'(bus.valid_out), 32'h1);
      bus.mode    = 1'b0;
      bus.data_in = 4'h3;
      tick();
      check_val("ms_rr", 32'(bus.valid_out), 32'h2);
      check_val("ms_rr_data", 32'(bus.data_out[1*WIDTH +: WIDTH]), 32'h3);
      bus.valid_in = 1'b0;
      tick();

      // Random traffic, checked by the scoreboard
      for (int n = 0; n < 300; n++) begin
         bus.mode      = 1'($urandom_range(0, 1));
         bus.sel_in    = 2'($urandom_range(0, 3));
         bus.valid_in  = 1'($urandom_range(0, 1));
         bus.data_in   = 4'($urandom);
         bus.ready_out = 3'($urandom);
         tick();
      end
      bus.valid_in  = 1'b0;
      bus.ready_out = 3'b111;
      tick();
      tick();
      check_val("final_idle", 32'(bus.valid_out), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/demux_valid_n.md
Name: demux_valid_n

Overview:
- Parametrised successor to the 2-way valid demux: routes a WIDTH-bit valid-qualified stream to NUM_OUT output channels.
- Each channel has a one-entry holding register with valid/ready back-pressure.
- Routing mode is selectable at run time: round-robin (mode=0) or explicit select (mode=1).
- Sits between the upstream stream source and per-lane consumers; data_tran is kept as a registered monitor tap.

Parameters:
- WIDTH, 4, data word width in bits.
- NUM_OUT, 2, number of output channels (>=2, need not be a power of two).
- SEL_W, derived localparam = max(1, clog2(NUM_OUT)), width of sel_in and of the round-robin pointer.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- mode  input  1  0 = round-robin routing, 1 = routing by sel_in; sampled every cycle.
- sel_in  input  SEL_W  target channel when mode=1; ignored when mode=0.
- valid_in  input  1  input word valid.
- data_in  input  WIDTH  input word.
- ready_in  output  1  combinational; a word transfers when valid_in && ready_in.
- ready_out  input  NUM_OUT  per-channel consumer ready.
- valid_out  output  NUM_OUT  per-channel valid; registered.
- data_out  output  NUM_OUT*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]; registered.
- data_tran  output  WIDTH  registered copy of the last accepted-or-dropped data_in.
- drop  output  1  one-cycle registered pulse marking a discarded word.

Behaviour:
- Reset (reset_L=0, asynchronous, any time): valid_out=0, data_out=0, data_tran=0, drop=0, rr pointer=0. This clears words held mid-transfer; no output is emitted for them.
- Target channel tgt: ptr when mode=0, sel_in when mode=1.
- Invalid target: mode=1 && sel_in>=NUM_OUT. Then ready_in=1, the word is consumed and discarded, and drop=1 in the next cycle. No valid_out changes and ptr is unchanged.
- Otherwise ready_in = !valid_out[tgt] || ready_out[tgt]. Ready depends only on the target slot; other full slots do not block.
- Accept (valid_in && ready_in, valid target):
  - Next cycle: valid_out[tgt]=1 and data_out slot tgt = data_in.
  - Latency is exactly 1 cycle.
- Drain: valid_out[i] && ready_out[i] with no load into i the same cycle clears valid_out[i] next cycle.
- Data on a drain is don't-care. The bench checks data only while valid_out[i]=1.
- Simultaneous drain and load on the same slot: the slot stays valid with the new word. This gives full throughput of 1 word/cycle per channel.
- Round-robin pointer:
  - Advances only on an accept while mode=0; wraps NUM_OUT-1 -> 0.
  - Holds while mode=1; no reset occurs on a mode change.
  - Back-pressure on the current target stalls the stream; it never skips to another channel.
- data_tran and drop:
  - data_tran updates to data_in on every cycle with valid_in && ready_in, including drops; it holds otherwise.
  - drop deasserts the cycle after a non-drop.
- valid_in=0: no state change except draining and the drop deassert.
- data_in is not required to be stable while valid_in=1 && ready_in=0. Nothing is captured until the transfer.

Test Plan:
- Reset and round-robin, WIDTH=4, NUM_OUT=2, mode=0, ready_out=2'b11: stream 0xA,0xB,0xC,0xD on consecutive cycles -> valid_out pattern 01,10,01,10. Channel 0 sees 0xA then 0xC; channel 1 sees 0xB then 0xD; each 1 cycle after input; data_tran tracks each word.
- Back-pressure: ready_out=2'b00, mode=0; send 0x1 (ch0) and 0x2 (ch1); then 0x3 targets ch0 -> ready_in=0 and 0x3 is held. Raise ready_out[0] -> 0x3 is accepted that cycle, ch0 shows 0x3 next cycle, and ch1 holds 0x2 with valid.
- Select mode, NUM_OUT=3: mode=1 with sel_in=2,2,0 and data 0x5,0x6,0x7, ready_out=3'b111 -> ch2 receives 0x5 then 0x6 back-to-back, ch0 receives 0x7, and ptr is unchanged afterwards.
- Drop, NUM_OUT=3: mode=1, sel_in=3, data 0xF -> ready_in=1, drop=1 for one cycle, valid_out=000, data_tran=0xF.
- Mid-operation reset: with ch0 and ch1 full and ready_out=0, pulse reset_L low between clock edges -> all outputs zero immediately. After release, mode=0 routes the first word to ch0.
- Mode switch: mode=0, accept 0x1 (ptr becomes 1); switch to mode=1 with sel_in=0 and send 0x2; return to mode=0 and send 0x3 -> 0x3 goes to ch1.
